execute_cycle: RTL
==================

Name: execute_cycle

Overview:
Execute stage of the 5-stage RISC-V pipeline. It sits directly downstream of the decode stage and consumes the decode stage's E-side registered outputs. It does the following:
- applies hazard-unit forwarding to both operands;
- performs the ALU operation;
- resolves BEQ branches and computes the branch target;
- registers results into the E/M pipeline register feeding the memory stage.

Parameters:
WIDTH, 32, datapath width (PC, operands, results)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-low reset
RegWriteE  input  1  register-file write enable for this instruction
ALUSrcE  input  1  0: SrcB = forwarded RD2; 1: SrcB = Imm_Ext_E
MemWriteE  input  1  store enable
ResultSrcE  input  1  0: ALU result to WB; 1: memory data to WB
BranchE  input  1  instruction is BEQ
ALUControlE  input  3  ALU operation select
RD1_E  input  WIDTH  rs1 read data
RD2_E  input  WIDTH  rs2 read data
Imm_Ext_E  input  WIDTH  sign-extended immediate
RD_E  input  5  destination register
PCE  input  WIDTH  PC of this instruction
PCPlus4E  input  WIDTH  PC+4 of this instruction
ResultW  input  WIDTH  writeback-stage result (forward source)
ForwardA_E  input  2  operand-A forward select
ForwardB_E  input  2  operand-B forward select
PCSrcE  output  1  branch taken; redirects fetch (combinational)
PCTargetE  output  WIDTH  PCE + Imm_Ext_E (combinational)
RegWriteM  output  1  registered RegWriteE
MemWriteM  output  1  registered MemWriteE
ResultSrcM  output  1  registered ResultSrcE
RD_M  output  5  registered RD_E
PCPlus4M  output  WIDTH  registered PCPlus4E
WriteDataM  output  WIDTH  registered forwarded-B value (store data, before the ALUSrc mux)
ALUResultM  output  WIDTH  registered ALU result; also the M-stage forward source

Behaviour:
- Clock and reset: one clock (clk); reset rst is asynchronous and active-low.
- While rst=0, all M outputs are 0: RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALUResultM. The clear takes effect immediately, not at the next edge.
- Reset mid-operation discards the in-flight instruction. The first edge after rst releases captures the current E inputs.

Forwarding (combinational):
- Select encoding, applied independently to A and B: 00 = RD1_E / RD2_E; 01 = ResultW; 10 = ALUResultM (the internal register); 11 = treated as 00.
- SrcA = forwarded A.
- SrcB = ALUSrcE ? Imm_Ext_E : forwarded B.

ALU (combinational, WIDTH bits, results wrap modulo 2^WIDTH):
- 000: ADD.
- 001: SUB (SrcA + ~SrcB + 1).
- 010: AND.
- 011: OR.
- 101: SLT, signed compare, result 1 or 0 zero-extended.
- Others: result 0.
- Zero = (result == 0), internal only.

Branch:
- PCSrcE = BranchE & Zero.
- PCTargetE = PCE + Imm_Ext_E, wraps on overflow.
- Both are combinational, with no internal state, and are valid in the same cycle the instruction is in E.

E/M register:
- Single stage. Every rising edge with rst=1 captures all M outputs.
- Latency is exactly 1 cycle from the E inputs to the M outputs.
- There is no stall or enable input. Bubbles arrive as zeroed control from the decode stage.
- Back-to-back dependent instructions: on the same edge that ALUResultM updates, the forward-10 path has already supplied the old ALUResultM value. There is no combinational loop, because the forward path reads the register output only.

Decomposition:
- Shared package holds:
  - ALU opcode constants: ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_AND=3'b010, ALU_OR=3'b011, ALU_SLT=3'b101;
  - forward-select constants: FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
- One sub-module, alu: SrcA, SrcB, ALUControl -> Result, Zero.
- Forward muxes, branch adder and E/M register live in execute_cycle.

Test Plan:
- Reset: drive rst=0 mid-cycle after loading non-zero values -> all M outputs read 0 immediately. After release, the first edge captures the inputs.
- ADD with immediate: RD1_E=5, Imm_Ext_E=7, ALUSrcE=1, ALUControlE=000, RegWriteE=1, RD_E=3 -> one edge later ALUResultM=12, RD_M=3, RegWriteM=1.
- Signed SLT and SUB wrap:
  - SLT: RD1_E=0xFFFFFFFF, RD2_E=1 -> ALUResultM=1.
  - SUB: RD1_E=0, RD2_E=1 -> ALUResultM=0xFFFFFFFF.
- Forwarding: cycle 1 ADD produces ALUResultM=0x10. Cycle 2 runs ForwardA_E=10, RD1_E=0 (stale), ForwardB_E=01, ResultW=0x20, ALUSrcE=0, ADD -> ALUResultM=0x30, and WriteDataM=0x20.
- BEQ taken and not taken, with PCE=0x100, Imm_Ext_E=0xFFFFFFF8, BranchE=1, ALUControlE=001:
  - RD1_E=RD2_E=9 -> PCSrcE=1 and PCTargetE=0xF8 in the same cycle.
  - RD2_E=8 -> PCSrcE=0.
- Store path: MemWriteE=1, ALUSrcE=1, RD2_E=0xDEADBEEF, RD1_E=0x40, Imm_Ext_E=4 -> ALUResultM=0x44, WriteDataM=0xDEADBEEF, MemWriteM=1.

Source files
------------

// File: rtl/execute_cycle_pkg.sv
// Shared constants for the execute stage: ALU opcodes and forward selects.
package execute_cycle_pkg;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
endpackage

// File: rtl/execute_cycle_alu.sv
// Combinational ALU for the execute stage; Zero drives BEQ resolution.
module alu
  import execute_cycle_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [2:0]       ALUControl,
  output logic [WIDTH-1:0] Result,
  output logic             Zero
);

  logic slt;

  // Operation select; unused encodings yield 0.
  always_comb begin
    slt    = ($signed(SrcA) < $signed(SrcB));
    Result = '0;
    case (ALUControl)
      ALU_ADD: Result = SrcA + SrcB;
      ALU_SUB: Result = SrcA + ~SrcB + {{(WIDTH-1){1'b0}}, 1'b1};
      ALU_AND: Result = SrcA & SrcB;
      ALU_OR:  Result = SrcA | SrcB;
      ALU_SLT: Result = {{(WIDTH-1){1'b0}}, slt};
      default: Result = '0;
    endcase
  end

  assign Zero = (Result == '0);

endmodule

// File: rtl/execute_cycle.sv
// Execute stage: operand forwarding, ALU, BEQ resolution, E/M pipeline register.
module execute_cycle
  import execute_cycle_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             RegWriteE,
  input  logic             ALUSrcE,
  input  logic             MemWriteE,
  input  logic             ResultSrcE,
  input  logic             BranchE,
  input  logic [2:0]       ALUControlE,
  input  logic [WIDTH-1:0] RD1_E,
  input  logic [WIDTH-1:0] RD2_E,
  input  logic [WIDTH-1:0] Imm_Ext_E,
  input  logic [4:0]       RD_E,
  input  logic [WIDTH-1:0] PCE,
  input  logic [WIDTH-1:0] PCPlus4E,
  input  logic [WIDTH-1:0] ResultW,
  input  logic [1:0]       ForwardA_E,
  input  logic [1:0]       ForwardB_E,
  output logic             PCSrcE,
  output logic [WIDTH-1:0] PCTargetE,
  output logic             RegWriteM,
  output logic             MemWriteM,
  output logic             ResultSrcM,
  output logic [4:0]       RD_M,
  output logic [WIDTH-1:0] PCPlus4M,
  output logic [WIDTH-1:0] WriteDataM,
  output logic [WIDTH-1:0] ALUResultM
);

  logic [WIDTH-1:0] src_a, fwd_b, src_b, alu_result;
  logic             zero;

  // Forward muxes; the MEM source is the register output, so no loop through the ALU.
  always_comb begin
    case (ForwardA_E)
      FWD_WB:  src_a = ResultW;
      FWD_MEM: src_a = ALUResultM;
      default: src_a = RD1_E;
    endcase
    case (ForwardB_E)
      FWD_WB:  fwd_b = ResultW;
      FWD_MEM: fwd_b = ALUResultM;
      default: fwd_b = RD2_E;
    endcase
    src_b = ALUSrcE ? Imm_Ext_E : fwd_b;
  end

  alu #(.WIDTH(WIDTH)) u_alu (
    .SrcA       (src_a),
    .SrcB       (src_b),
    .ALUControl (ALUControlE),
    .Result     (alu_result),
    .Zero       (zero)
  );

  assign PCSrcE    = BranchE & zero;
  assign PCTargetE = PCE + Imm_Ext_E;

  // E/M register; reset clears immediately and drops the in-flight instruction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= 1'b0;
      RD_M       <= '0;
      PCPlus4M   <= '0;
      WriteDataM <= '0;
      ALUResultM <= '0;
    end else begin
      RegWriteM  <= RegWriteE;
      MemWriteM  <= MemWriteE;
      ResultSrcM <= ResultSrcE;
      RD_M       <= RD_E;
      PCPlus4M   <= PCPlus4E;
      WriteDataM <= fwd_b;
      ALUResultM <= alu_result;
    end
  end

endmodule
